// File: rtl/vdf_sq_sequencer.sv
// vdf_sq_sequencer: steps one redun_mont squaring core through T squarings, with a watchdog on the core's output pulses
module vdf_sq_sequencer #(
  parameter int DAT_W        = 1040,
  parameter int ITER_W       = 64,
  parameter int CORE_RST_CYC = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DAT_W-1:0]  i_sq,
  input  logic [ITER_W-1:0] i_iter,
  input  logic              i_ack,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DAT_W-1:0]  o_result,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic              o_core_rst,
  output logic [DAT_W-1:0]  o_core_sq,
  output logic              o_core_val,
  input  logic [DAT_W-1:0]  i_core_mul,
  input  logic              i_core_val
);
  localparam int RC_W = $clog2(CORE_RST_CYC + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CRST = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;
  logic [2:0]        st, nxt;
  logic [DAT_W-1:0]  sq_r;
  logic [ITER_W-1:0] iter_r;
  logic [RC_W-1:0]   rc;
  logic [WD_W-1:0]   wd;
  logic              fin, tmo, run;
  assign fin = i_core_val && (o_iter_cnt + ITER_W'(1) == iter_r);
  assign tmo = !i_core_val && (wd == WD_W'(TIMEOUT - 1));
  assign run = st == RUN && !i_abort;
  // abort outranks completion, completion outranks timeout
  always_comb begin
    nxt = st == IDLE ? (i_start ? (i_iter == '0 ? DONE : CRST) : IDLE) :
          (st == DONE || st == ERR) ? (i_ack ? IDLE : st) :
          i_abort ? IDLE :
          st == CRST ? (rc == '0 ? LOAD : CRST) :
          st == LOAD ? RUN :
          st == RUN ? (fin ? DONE : tmo ? ERR : RUN) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st         <= IDLE;
      sq_r       <= '0;
      iter_r     <= '0;
      rc         <= '0;
      wd         <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_result   <= '0;
      o_iter_cnt <= '0;
      o_core_rst <= 1'b1;
      o_core_sq  <= '0;
      o_core_val <= 1'b0;
    end else begin
      st         <= nxt;
      o_busy     <= nxt == CRST || nxt == LOAD || nxt == RUN;
      o_done     <= nxt == DONE;
      o_err      <= nxt == ERR;
      o_core_rst <= !(nxt == LOAD || nxt == RUN);
      o_core_val <= nxt == LOAD;
      if (nxt == LOAD) o_core_sq <= sq_r;
      if (st == IDLE && i_start) begin
        sq_r       <= i_sq;
        iter_r     <= i_iter;
        o_iter_cnt <= '0;
        rc         <= RC_W'(CORE_RST_CYC - 1);
        if (i_iter == '0) o_result <= i_sq;
      end
      if (st == CRST) rc <= rc - RC_W'(1);
      if (st == LOAD) wd <= '0;
      if (run && i_core_val) begin
        o_iter_cnt <= o_iter_cnt + ITER_W'(1);
        wd         <= '0;
        if (fin) o_result <= i_core_mul;
      end else if (run) wd <= wd + WD_W'(1);
    end
  end
endmodule

// File: tb/tb_vdf_sq_sequencer.sv
// tb_vdf_sq_sequencer: timeline reference model plus directed and random scenarios for vdf_sq_sequencer
module tb_vdf_sq_sequencer;
  localparam int DAT_W = 1040;
  localparam int ITER_W = 64;
  localparam int TO = 1024;
  logic clk = 0, rst = 1, start = 0, ack = 0, ab_main = 0, ab_drv = 0, core_val = 0;
  logic abort;
  logic [DAT_W-1:0] sq = '0, core_mul = '0;
  logic [ITER_W-1:0] iter = '0;
  logic busy, done, err, core_rst, cval;
  logic [DAT_W-1:0] res, csq;
  logic [ITER_W-1:0] icnt;
  assign abort = ab_main | ab_drv;
  always #5 clk = ~clk;
  vdf_sq_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sq(sq), .i_iter(iter),
    .i_ack(ack), .i_abort(abort), .o_busy(busy), .o_done(done), .o_err(err),
    .o_result(res), .o_iter_cnt(icnt), .o_core_rst(core_rst), .o_core_sq(csq),
    .o_core_val(cval), .i_core_mul(core_mul), .i_core_val(core_val)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [DAT_W-1:0] a, input logic [DAT_W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (low 128 bits) at %0t", nm, a[127:0], e[127:0], $time);
    end
  endtask
  function automatic logic [DAT_W-1:0] rnd_dat();
    logic [DAT_W-1:0] r = '0;
    for (int i = 0; i <= DAT_W / 32; i++) r = {r[DAT_W-33:0], $urandom};
    return r;
  endfunction
  // core stand-in: pulses every cur_gap cycles once released from reset
  int gap = 20, cur_gap = 20, stall_at = 1 << 30, abort_at = 0, spur = 0, rnd = 0, ccnt = 0, npulse = 0;
  logic [DAT_W-1:0] pm [16];
  always @(negedge clk) begin
    core_val = 0;
    ab_drv = 0;
    if (core_rst !== 1'b0) begin
      ccnt = 0;
      npulse = 0;
      cur_gap = rnd ? $urandom_range(1, 40) : gap;
      if (rnd) stall_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 1 << 30;
    end else begin
      ccnt++;
      if (ccnt >= cur_gap && npulse < stall_at) begin
        core_val = 1;
        core_mul = rnd_dat();
        ccnt = 0;
        npulse++;
        if (npulse <= 16) pm[npulse-1] = core_mul;
        if (npulse == abort_at) ab_drv = 1;
        if (rnd) cur_gap = $urandom_range(1, 40);
      end
    end
    if (spur != 0) begin
      core_val = 1;
      core_mul = rnd_dat();
    end
  end
  // reference model: mode 0 idle, 1 active, 2 done, 3 error; age = cycles since the accepted start
  int m_mode = 0, m_age = 0, m_quiet = 0;
  logic [ITER_W-1:0] m_cnt = '0, m_t = '0;
  logic [DAT_W-1:0] m_sq = '0, m_res = '0;
  bit started = 0;
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_mode = 0;
      m_cnt = '0;
      m_res = '0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_sq = sq;
        m_t = iter;
        m_cnt = '0;
        m_age = 1;
        m_quiet = 0;
        if (iter == 0) begin
          m_res = sq;
          m_mode = 2;
        end else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (abort) m_mode = 0;
      else begin
        if (m_age >= 6) begin
          if (core_val) begin
            m_cnt = m_cnt + 1;
            m_quiet = 0;
            if (m_cnt == m_t) begin
              m_res = core_mul;
              m_mode = 2;
            end
          end else begin
            m_quiet++;
            if (m_quiet == TO) m_mode = 3;
          end
        end
        m_age++;
      end
    end else if (ack) m_mode = 0;
  end
  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy, m_mode == 1);
      chk("done", done, m_mode == 2);
      chk("err", err, m_mode == 3);
      chk("core_rst", core_rst, !(m_mode == 1 && m_age >= 5));
      chk("core_val", cval, m_mode == 1 && m_age == 5);
      if (m_mode == 1 && m_age == 5) chk("core_sq", csq, m_sq);
      chk("iter_cnt", icnt, m_cnt);
      chk("result", res, m_res);
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic go(input logic [ITER_W-1:0] t, input logic [DAT_W-1:0] v);
    start = 1;
    iter = t;
    sq = v;
    tick();
    start = 0;
  endtask
  task automatic do_ack();
    ack = 1;
    tick();
    ack = 0;
  endtask
  int k;
  logic [DAT_W-1:0] prev;
  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_result", res, 0);
    go(0, 5);
    chk("t0_done", done, 1);
    chk("t0_result", res, 5);
    chk("t0_core_rst", core_rst, 1);
    chk("t0_cnt", icnt, 0);
    do_ack();
    start = 1;
    iter = 3;
    sq = rnd_dat();
    k = 0;
    do begin
      tick();
      start = 0;
      k++;
    end while (!cval && k < 20);
    chk("load_latency", k, 5);
    k = 0;
    while (!done && k < 300) begin tick(); k++; end
    chk("t3_done", done, 1);
    chk("t3_result", res, pm[2]);
    chk("t3_cnt", icnt, 3);
    chk("t3_core_rst", core_rst, 1);
    do_ack();
    stall_at = 4;
    go(10, rnd_dat());
    k = 0;
    while (!err && k < 2000) begin tick(); k++; end
    chk("to_err", err, 1);
    chk("to_cnt", icnt, 4);
    do_ack();
    chk("to_ack_core_rst", core_rst, 1);
    chk("to_ack_err", err, 0);
    stall_at = 1 << 30;
    prev = res;
    abort_at = 5;
    go(5, rnd_dat());
    k = 0;
    while (busy && k < 500) begin tick(); k++; end
    abort_at = 0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_result", res, prev);
    chk("ab_cnt", icnt, 4);
    go(3, rnd_dat());
    k = 0;
    while (icnt != 1 && k < 200) begin tick(); k++; end
    start = 1;
    iter = 1;
    ack = 1;
    tick();
    start = 0;
    ack = 0;
    chk("ign_busy", busy, 1);
    k = 0;
    while (!done && k < 300) begin tick(); k++; end
    chk("ign_cnt", icnt, 3);
    prev = res;
    go(0, rnd_dat());
    chk("ign_done_start", done, 1);
    chk("ign_done_result", res, prev);
    do_ack();
    spur = 1;
    repeat (3) tick();
    spur = 0;
    tick();
    chk("spur_cnt", icnt, 3);
    chk("spur_busy", busy, 0);
    gap = 10;
    go(8, rnd_dat());
    k = 0;
    while (icnt != 2 && k < 200) begin tick(); k++; end
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_result", res, 0);
    chk("mrst_cnt", icnt, 0);
    chk("mrst_core_rst", core_rst, 1);
    go(1, rnd_dat());
    k = 0;
    while (!done && k < 200) begin tick(); k++; end
    chk("t1_done", done, 1);
    chk("t1_result", res, pm[0]);
    chk("t1_cnt", icnt, 1);
    do_ack();
    rnd = 1;
    for (int c = 0; c < 30000; c++) begin
      rst = $urandom_range(0, 999) == 0;
      start = $urandom_range(0, 9) == 0;
      k = $urandom_range(0, 19);
      iter = k == 0 ? '1 : k < 3 ? '0 : ITER_W'($urandom_range(1, 6));
      sq = rnd_dat();
      ack = $urandom_range(0, 4) == 0;
      ab_main = $urandom_range(0, 299) == 0;
      spur = $urandom_range(0, 99) == 0 ? 1 : 0;
      tick();
    end
    {rst, start, ack, ab_main} = '0;
    spur = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vdf_sq_sequencer.md
Name: vdf_sq_sequencer

Overview:
Sequences one redun_mont repeated-squaring core through a programmable number of squarings T.
- Holds the core in reset, loads the initial value, counts core output pulses and captures the T-th result.
- Stops the core on completion and reports done, or error on a watchdog timeout.
- Sits between the host/register interface and the core, in the same SLR.

Parameters:
DAT_W, 1040, width of the redundant operand (NUM_WRDS*(WRD_BITS+1)), passed flat
ITER_W, 64, width of iteration count
CORE_RST_CYC, 4, cycles o_core_rst is held in CRST before a load
TIMEOUT, 1024, maximum cycles allowed between consecutive core o_val pulses in RUN

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
i_start  in  1  start request, sampled in IDLE only
i_sq  in  DAT_W  initial value, latched on accepted start
i_iter  in  ITER_W  number of squarings T, latched on accepted start
i_ack  in  1  clears DONE/ERR
i_abort  in  1  abandon current run
o_busy  out  1  high in CRST, LOAD, RUN
o_done  out  1  high in DONE
o_err  out  1  high in ERR
o_result  out  DAT_W  captured result (x^(2^T) in Montgomery domain)
o_iter_cnt  out  ITER_W  squarings completed in current/last run
o_core_rst  out  1  drives core i_rst
o_core_sq  out  DAT_W  drives core i_sq
o_core_val  out  1  drives core i_val
i_core_mul  in  DAT_W  core o_mul
i_core_val  in  1  core o_val

Behaviour:
- Reset: state IDLE; o_busy/o_done/o_err/o_core_val=0; o_result, o_iter_cnt, o_core_sq=0; o_core_rst=1.
- o_core_rst=1 in IDLE, CRST, DONE, ERR; 0 in LOAD, RUN. All outputs are registered.
- IDLE: on i_start, latch i_sq→sq_r and i_iter→iter_r, clear o_iter_cnt.
  - If i_iter==0: o_result<=i_sq, go to DONE next cycle; the core is never released.
  - Otherwise go to CRST.
- CRST: hold for exactly CORE_RST_CYC cycles (down-counter), then LOAD.
- LOAD: exactly 1 cycle with o_core_val=1, o_core_sq=sq_r; then RUN.
- RUN:
  - Each i_core_val increments o_iter_cnt and reloads the watchdog to 0.
  - Otherwise the watchdog increments each cycle.
  - On i_core_val with o_iter_cnt+1==iter_r: o_result<=i_core_mul, go to DONE. o_core_rst rises the next cycle, so the core never delivers a (T+1)-th result to the sequencer.
  - Watchdog reaching TIMEOUT-1 with no i_core_val: go to ERR; o_result is unchanged.
- DONE/ERR: hold until i_ack, then IDLE. i_start is ignored in these states; i_ack is ignored in all other states.
- i_abort in CRST/LOAD/RUN: go to IDLE next cycle; o_result unchanged, o_iter_cnt frozen, no done/err. i_abort in IDLE/DONE/ERR is ignored.
- Simultaneous events:
  - i_abort wins over a final i_core_val and over a timeout.
  - A final i_core_val wins over a timeout in the same cycle.
  - i_core_val outside RUN is ignored; it is not counted.
- i_rst mid-run: immediate return to reset values on the next edge. The core is held in reset from that cycle.
- Counters: o_iter_cnt is ITER_W wide, no wrap (the final pulse terminates before wrap). iter_r=2^ITER_W-1 is legal.
- Latency:
  - start→o_core_val = CORE_RST_CYC+1 cycles.
  - final i_core_val→o_done = 1 cycle.
  - T=0: start→o_done = 1 cycle.

Test Plan:
- T=0, i_sq=0x5: o_done 1 cycle after start, o_result=0x5, o_core_rst stays 1, o_iter_cnt=0.
- T=3, core model pulsing every 20 cycles with results A,B,C: o_core_val 5 cycles after start; o_result=C, o_iter_cnt=3; o_core_rst=1 the cycle after the C pulse.
- T=10, model stalls after pulse 4 for 1024 cycles: o_err asserts; o_iter_cnt=4; i_ack→IDLE with o_core_rst=1.
- T=5, i_abort coincident with the 5th i_core_val: IDLE, no o_done, o_result unchanged from prior run, o_iter_cnt=4.
- i_start pulsed during RUN and in DONE, spurious i_core_val in IDLE, i_ack in RUN: all ignored; state and counters unchanged.
- i_rst asserted during RUN at count 2: next cycle all outputs at reset values; a subsequent start with T=1 completes normally.
